// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - register offsets, bit indices and CTRL layout for the APB UART block
package uart_apb_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_STATUS   = 5'h04;
    localparam logic [4:0] OFF_TXDATA   = 5'h08;
    localparam logic [4:0] OFF_RXDATA   = 5'h0C;
    localparam logic [4:0] OFF_BAUDDIV  = 5'h10;
    localparam logic [4:0] OFF_IRQ_EN   = 5'h14;
    localparam logic [4:0] OFF_IRQ_STAT = 5'h18;
    localparam logic [4:0] OFF_UNMAPPED = 5'h1C;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_RX_COUNT   = 8;
    localparam int ST_TX_COUNT   = 16;

    localparam int IRQ_RX_AVAIL  = 0;
    localparam int IRQ_TX_EMPTY  = 1;
    localparam int IRQ_OVERRUN   = 2;

    typedef struct packed {
        logic rx_flush;
        logic tx_flush;
        logic rx_en;
        logic tx_en;
    } ctrl_t;

endpackage

// File: rtl/apb_uart_ctrl_if.sv
// rtl/apb_uart_ctrl_if.sv - APB3 bus bundle for the UART register block
interface apb_uart_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with extra-MSB pointers and flush
module uart_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot, so a full FIFO may accept a same-cycle push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + CW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/apb_uart_ctrl.sv
// rtl/apb_uart_ctrl.sv - APB3 register block with TX/RX FIFOs, baud divisor and interrupt
module apb_uart_ctrl
    import uart_apb_pkg::*;
#(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BAUD_RST   = 16'd868,
    parameter int          ADDR_W     = 32
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_uart_ctrl_if.slave       apb,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rx_valid,
    output logic [15:0]          baud_div,
    output logic                 irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ctrl_t       ctrl_q;
    ctrl_t       ctrl_wdata;
    logic [15:0] baud_q;
    logic [2:0]  irq_en_q;
    logic        overrun_q;
    logic        irq_q;

    logic        access, wr, rd;
    logic [4:0]  reg_off;
    logic        tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic        overrun_set, overrun_clr;
    logic [CW-1:0]     tx_count, rx_count;
    logic [DATA_W-1:0] rx_dout;
    logic [2:0]  irq_stat;
    logic [31:0] status;
    logic [31:0] prdata;
    logic        unused_apb;

    // Reset also masks the bus so PRDATA/PSLVERR read 0 while PRESETn is low.
    assign access  = apb.PSEL & apb.PENABLE & PRESETn;
    assign wr      = access & apb.PWRITE;
    assign rd      = access & ~apb.PWRITE;
    assign reg_off = {apb.PADDR[4:2], 2'b00};
    assign ctrl_wdata = ctrl_t'(apb.PWDATA[3:0]);

    assign tx_flush = wr && (reg_off == OFF_CTRL) && ctrl_wdata.tx_flush;
    assign rx_flush = wr && (reg_off == OFF_CTRL) && ctrl_wdata.rx_flush;
    assign tx_push  = wr && (reg_off == OFF_TXDATA) && !tx_full;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & ctrl_q.rx_en & ~rx_full;
    assign rx_pop   = rd && (reg_off == OFF_RXDATA) && !rx_empty;

    assign overrun_set = rx_valid & ctrl_q.rx_en & rx_full;
    assign overrun_clr = wr && (reg_off == OFF_IRQ_STAT) && apb.PWDATA[IRQ_OVERRUN];

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (apb.PWDATA[DATA_W-1:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (rx_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign tx_valid = ctrl_q.tx_en & ~tx_empty;
    assign irq_stat = {overrun_q, tx_empty, ~rx_empty};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q    <= '0;
            baud_q    <= BAUD_RST;
            irq_en_q  <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (wr && reg_off == OFF_CTRL) begin
                ctrl_q.tx_en <= ctrl_wdata.tx_en;
                ctrl_q.rx_en <= ctrl_wdata.rx_en;
            end
            if (wr && reg_off == OFF_BAUDDIV) baud_q   <= apb.PWDATA[15:0];
            if (wr && reg_off == OFF_IRQ_EN)  irq_en_q <= apb.PWDATA[2:0];
            if (overrun_set)      overrun_q <= 1'b1;
            else if (overrun_clr) overrun_q <= 1'b0;
            irq_q <= |(irq_stat & irq_en_q);
        end
    end

    always_comb begin
        status = '0;
        status[ST_TX_FULL]         = tx_full;
        status[ST_TX_EMPTY]        = tx_empty;
        status[ST_RX_FULL]         = rx_full;
        status[ST_RX_EMPTY]        = rx_empty;
        status[ST_RX_OVERRUN]      = overrun_q;
        status[ST_RX_COUNT +: CW]  = rx_count;
        status[ST_TX_COUNT +: CW]  = tx_count;
    end

    always_comb begin
        prdata = '0;
        if (rd) begin
            case (reg_off)
                OFF_CTRL:     prdata[1:0] = {ctrl_q.rx_en, ctrl_q.tx_en};
                OFF_STATUS:   prdata = status;
                OFF_RXDATA:   if (!rx_empty) prdata[DATA_W-1:0] = rx_dout;
                OFF_BAUDDIV:  prdata[15:0] = baud_q;
                OFF_IRQ_EN:   prdata[2:0] = irq_en_q;
                OFF_IRQ_STAT: prdata[2:0] = irq_stat;
                default:      prdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = (wr && reg_off == OFF_TXDATA && tx_full)
                       | (rd && reg_off == OFF_RXDATA && rx_empty)
                       | (access && reg_off == OFF_UNMAPPED);

    assign baud_div = baud_q;
    assign irq      = irq_q;

    assign unused_apb = ^{apb.PADDR[ADDR_W-1:5], apb.PADDR[1:0], apb.PWDATA[31:16]};

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// tb/tb_apb_uart_ctrl.sv - randomized self-checking bench with queue-based reference model
module tb_apb_uart_ctrl;
    import uart_apb_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [DATA_W-1:0] tx_data, rx_data;
    logic tx_valid, tx_ready, rx_valid, irq;
    logic [15:0] baud_div;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] txq[$];
    logic [DATA_W-1:0] rxq[$];
    logic m_ovr = 1'b0;
    logic m_tx_en = 1'b0;
    logic m_rx_en = 1'b0;
    logic [2:0] m_irq_en = '0;

    apb_uart_ctrl_if #(.ADDR_W(32)) bus ();

    apb_uart_ctrl #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .BAUD_RST(16'd868), .ADDR_W(32)) dut (
        .PCLK(clk), .PRESETn(rst_n), .apb(bus),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .baud_div(baud_div), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        int t = txq.size();
        int r = rxq.size();
        logic [31:0] s = '0;
        s[0] = (t == DEPTH);
        s[1] = (t == 0);
        s[2] = (r == DEPTH);
        s[3] = (r == 0);
        s[4] = m_ovr;
        s[12:8]  = 5'(r);
        s[20:16] = 5'(t);
        return s;
    endfunction

    function automatic logic [31:0] exp_irqstat();
        return {29'b0, m_ovr, txq.size() == 0, rxq.size() != 0};
    endfunction

    task automatic apb_xfer(input logic wr, input logic [4:0] off, input logic [31:0] wdata,
                            input bit strobe, input logic [DATA_W-1:0] sdata,
                            output logic [31:0] rdata, output logic err);
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = {27'b0, off}; bus.PWDATA = wdata;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        if (strobe) begin rx_valid = 1'b1; rx_data = sdata; end
        #1 rdata = bus.PRDATA; err = bus.PSLVERR;
        @(posedge clk);
        #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic apb_wr(input logic [4:0] off, input logic [31:0] d, output logic err);
        logic [31:0] rd;
        apb_xfer(1'b1, off, d, 1'b0, '0, rd, err);
    endtask

    task automatic apb_rd(input logic [4:0] off, output logic [31:0] rd, output logic err);
        apb_xfer(1'b0, off, 32'h0, 1'b0, '0, rd, err);
    endtask

    task automatic rx_strobe(input logic [DATA_W-1:0] d);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d;
        @(negedge clk);
        rx_valid = 1'b0;
        if (m_rx_en) begin
            if (rxq.size() == DEPTH) m_ovr = 1'b1;
            else rxq.push_back(d);
        end
    endtask

    task automatic set_ctrl(input logic [31:0] v);
        logic e;
        apb_wr(OFF_CTRL, v, e);
        m_tx_en = v[0]; m_rx_en = v[1];
        if (v[2]) txq.delete();
        if (v[3]) rxq.delete();
    endtask

    task automatic tx_write(input logic [DATA_W-1:0] d, input string nm);
        logic e;
        logic exp_e;
        exp_e = (txq.size() == DEPTH);
        apb_wr(OFF_TXDATA, {24'b0, d}, e);
        total++; if (e !== exp_e) begin bad++; $display("FAIL %s_err got=%b exp=%b", nm, e, exp_e); end
        if (!exp_e) txq.push_back(d);
    endtask

    task automatic rx_read(input string nm);
        logic [31:0] rd;
        logic e, exp_e;
        logic [31:0] exp_d;
        exp_e = (rxq.size() == 0);
        exp_d = exp_e ? 32'h0 : {24'b0, rxq[0]};
        apb_rd(OFF_RXDATA, rd, e);
        if (!exp_e) void'(rxq.pop_front());
        total++; if (e !== exp_e) begin bad++; $display("FAIL %s_err got=%b exp=%b", nm, e, exp_e); end
        total++; if (rd !== exp_d) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, rd, exp_d); end
    endtask

    task automatic check_reg(input logic [4:0] off, input logic [31:0] exp_v, input string nm);
        logic [31:0] rd;
        logic e;
        apb_rd(off, rd, e);
        total++; if (rd !== exp_v) begin bad++; $display("FAIL %s got=%h exp=%h", nm, rd, exp_v); end
    endtask

    task automatic tx_drain(input string nm);
        @(negedge clk);
        tx_ready = 1'b1;
        while (txq.size() != 0) begin
            #1;
            total++;
            if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
                bad++; $display("FAIL %s got=%b/%h exp=1/%h", nm, tx_valid, tx_data, txq[0]);
            end
            void'(txq.pop_front());
            @(negedge clk);
        end
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL %s_end got=%b exp=0", nm, tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic e;
        repeat (2) @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
        total++; if (bus.PREADY !== 1'b1) begin bad++; $display("FAIL rst_pready got=%b exp=1", bus.PREADY); end
        total++; if (baud_div !== 16'd868) begin bad++; $display("FAIL rst_baud got=%h exp=%h", baud_div, 16'd868); end
        rst_n = 1'b1;
        check_reg(OFF_CTRL, 32'h0, "rst_ctrl");
        check_reg(OFF_STATUS, 32'h0000_000A, "rst_status");
        check_reg(OFF_BAUDDIV, 32'h0000_0364, "rst_bauddiv");
        check_reg(OFF_IRQ_EN, 32'h0, "rst_irq_en");
        check_reg(OFF_IRQ_STAT, 32'h2, "rst_irq_stat");
        apb_rd(OFF_UNMAPPED, rd, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL rst_unmapped_err got=%b exp=1", e); end
    endtask

    task automatic test_tx_fill();
        set_ctrl(32'h1);
        for (int i = 0; i < 17; i++) tx_write(8'(8'h41 + i), "txfill");
        check_reg(OFF_STATUS, exp_status(), "txfill_status");
        check_reg(OFF_STATUS, 32'h0010_0009, "txfill_status_abs");
        tx_drain("txfill_drain");
    endtask

    task automatic test_rx_irq();
        logic e;
        set_ctrl(32'h2);
        rx_strobe(8'hA5); rx_strobe(8'h5A); rx_strobe(8'h3C);
        apb_wr(OFF_IRQ_EN, 32'h1, e); m_irq_en = 3'h1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rxirq_irq_hi got=%b exp=1", irq); end
        for (int i = 0; i < 4; i++) rx_read("rxirq_read");
        repeat (2) @(negedge clk);
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rxirq_irq_lo got=%b exp=0", irq); end
        apb_wr(OFF_IRQ_EN, 32'h0, e); m_irq_en = 3'h0;
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        logic e;
        for (int i = 0; i < 16; i++) rx_strobe(8'(8'h10 + i));
        rx_strobe(8'hFF);
        check_reg(OFF_IRQ_STAT, exp_irqstat(), "ovr_irqstat_set");
        check_reg(OFF_STATUS, exp_status(), "ovr_status");
        apb_wr(OFF_IRQ_STAT, 32'h4, e); m_ovr = 1'b0;
        check_reg(OFF_IRQ_STAT, exp_irqstat(), "ovr_irqstat_clr");
        apb_xfer(1'b1, OFF_IRQ_STAT, 32'h4, 1'b1, 8'hEE, rd, e);
        m_ovr = 1'b1;
        check_reg(OFF_IRQ_STAT, 32'h7, "ovr_set_wins");
        for (int i = 0; i < 17; i++) rx_read("ovr_read");
        apb_wr(OFF_IRQ_STAT, 32'h4, e); m_ovr = 1'b0;
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        logic e;
        logic [15:0] b;
        logic [31:0] ie;
        b = 16'($urandom);
        apb_wr(OFF_BAUDDIV, {$urandom_range(0, 65535), b}, e);
        check_reg(OFF_BAUDDIV, {16'h0, b}, "regs_baud");
        total++; if (baud_div !== b) begin bad++; $display("FAIL regs_baud_port got=%h exp=%h", baud_div, b); end
        ie = $urandom;
        apb_wr(OFF_IRQ_EN, ie, e);
        check_reg(OFF_IRQ_EN, {29'b0, ie[2:0]}, "regs_irq_en");
        apb_wr(OFF_IRQ_EN, 32'h0, e);
        apb_rd(OFF_TXDATA, rd, e);
        total++; if (rd !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL regs_txdata_rd got=%h/%b exp=0/0", rd, e); end
        apb_wr(OFF_RXDATA, 32'h77, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL regs_rxdata_wr got=%b exp=0", e); end
        apb_wr(OFF_UNMAPPED, 32'hFFFF_FFFF, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL regs_unmapped_wr got=%b exp=1", e); end
        check_reg(OFF_STATUS, exp_status(), "regs_status");
    endtask

    task automatic test_back_to_back();
        logic e;
        logic [DATA_W-1:0] v;
        set_ctrl(32'h1);
        for (int i = 0; i < 8; i++) tx_write(8'($urandom), "b2b_fill");
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = {27'b0, OFF_TXDATA}; bus.PWDATA = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.PENABLE = 1'b1; tx_ready = 1'b1;
            v = 8'($urandom);
            bus.PWDATA = {24'b0, v};
            #1;
            total++;
            if (tx_valid !== 1'b1 || tx_data !== txq[0] || bus.PSLVERR !== 1'b0) begin
                bad++; $display("FAIL b2b_stream got=%b/%h/%b exp=1/%h/0", tx_valid, tx_data, bus.PSLVERR, txq[0]);
            end
            @(posedge clk);
            void'(txq.pop_front());
            txq.push_back(v);
        end
        #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; tx_ready = 1'b0;
        check_reg(OFF_STATUS, exp_status(), "b2b_count");
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = {27'b0, OFF_CTRL}; bus.PWDATA = 32'h5;
        @(negedge clk);
        bus.PENABLE = 1'b1; tx_ready = 1'b1;
        @(posedge clk);
        #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; tx_ready = 1'b0;
        txq.delete();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL b2b_flush_valid got=%b exp=0", tx_valid); end
        check_reg(OFF_STATUS, exp_status(), "b2b_flush_status");
        check_reg(OFF_CTRL, 32'h1, "b2b_ctrl_rb");
    endtask

    task automatic test_random();
        int op;
        set_ctrl(32'h3);
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3)      tx_write(8'($urandom), "rnd_tx");
            else if (op <= 5) rx_read("rnd_rx");
            else if (op <= 7) rx_strobe(8'($urandom));
            else begin
                check_reg(OFF_STATUS, exp_status(), "rnd_status");
                check_reg(OFF_IRQ_STAT, exp_irqstat(), "rnd_irqstat");
            end
        end
        tx_drain("rnd_drain");
        while (rxq.size() != 0) rx_read("rnd_rx_drain");
    endtask

    task automatic test_reset_mid();
        logic e;
        set_ctrl(32'h3);
        apb_wr(OFF_IRQ_EN, 32'h1, e); m_irq_en = 3'h1;
        for (int i = 0; i < 5; i++) tx_write(8'($urandom), "rmid_tx");
        for (int i = 0; i < 4; i++) rx_strobe(8'($urandom));
        repeat (2) @(negedge clk);
        #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rmid_irq_pre got=%b exp=1", irq); end
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = {27'b0, OFF_STATUS};
        @(negedge clk);
        bus.PENABLE = 1'b1; tx_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        txq.delete(); rxq.delete(); m_ovr = 1'b0; m_tx_en = 1'b0; m_rx_en = 1'b0; m_irq_en = '0;
        total++;
        if (tx_valid !== 1'b0 || irq !== 1'b0 || bus.PSLVERR !== 1'b0 || bus.PRDATA !== 32'h0
            || bus.PREADY !== 1'b1 || baud_div !== 16'd868) begin
            bad++; $display("FAIL rmid_outputs got=%b/%b/%b/%h/%b/%h exp=0/0/0/0/1/0364",
                            tx_valid, irq, bus.PSLVERR, bus.PRDATA, bus.PREADY, baud_div);
        end
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reg(OFF_STATUS, exp_status(), "rmid_status");
        check_reg(OFF_CTRL, 32'h0, "rmid_ctrl");
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rmid_tx_valid got=%b exp=0", tx_valid); end
    endtask

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        test_reset();
        test_tx_fill();
        test_rx_irq();
        test_overrun();
        test_regs();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
